// File: rtl/timer_ntick.sv
// rtl/timer_ntick.sv - parametrised tick timer with prescaler, free-run/one-shot modes and load
module timer_ntick #(
    parameter int N_TICKS  = 8,
    parameter int PRESCALE = 1,
    parameter int W        = (N_TICKS > 1) ? $clog2(N_TICKS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         mode,
    input  logic         start,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] next_tick,
    output logic         tick,
    output logic         wrap,
    output logic         busy
);

    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [W-1:0]  LAST  = W'(N_TICKS - 1);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (!mode || start) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (presc_q == PLAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (count_q == LAST) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                            // mode is only consulted here, so a mid-run change lands at the wrap
                            if (mode) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Load overrides any advance on the same edge but never ends a run
        if (load) begin
            count_d = (load_value > LAST) ? LAST : load_value;
            presc_d = '0;
            tick_d  = 1'b0;
            wrap_d  = 1'b0;
            if (state_q == RUN) begin
                state_d = RUN;
            end
        end
    end

    assign next_tick = count_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q == RUN);

endmodule
